// File: rtl/stepper_phase_decoder.sv
// Stepper coil phase decoder: synchronises and debounces the 4-bit coil drive,
// checks the full-step phase sequence and tracks car position, floor and direction.
module stepper_phase_decoder #(
   parameter int unsigned STEPS_PER_FLOOR = 48,
   parameter int unsigned NUM_FLOORS      = 9,
   parameter int unsigned STABLE_CYCLES   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [3:0]                         coil_in,
   input  logic                               clear_fault,
   output logic                               step_pulse,
   output logic                               step_dir,
   output logic [3:0]                         floor,
   output logic [$clog2(STEPS_PER_FLOOR)-1:0] sub_step,
   output logic                               at_floor,
   output logic                               idle,
   output logic                               fault,
   output logic [1:0]                         fault_code
);

   localparam int unsigned SW = $clog2(STEPS_PER_FLOOR);
   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   localparam logic [SW-1:0] SUB_MAX   = SW'(STEPS_PER_FLOOR - 1);
   localparam logic [3:0]    TOP_FLOOR = 4'(NUM_FLOORS - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(STABLE_CYCLES);

   localparam logic [3:0] CODE_P0  = 4'b1001;
   localparam logic [3:0] CODE_P1  = 4'b1010;
   localparam logic [3:0] CODE_P2  = 4'b0110;
   localparam logic [3:0] CODE_P3  = 4'b0101;
   localparam logic [3:0] CODE_OFF = 4'b0000;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_SKIP    = 2'b10;
   localparam logic [1:0] FC_OVER    = 2'b11;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_TRACK, S_FAULT} state_t;

   logic [3:0]    sync1, sync2, cand, last_acc;
   logic [CW-1:0] cnt;
   logic          accept;

   logic          ph_valid;
   logic [1:0]    ph_idx, ref_idx, diff;

   state_t        state, state_nx;
   logic [1:0]    ref_nx, fcode_nx;
   logic [3:0]    floor_nx;
   logic [SW-1:0] sub_nx;
   logic          dir_nx, pulse_nx;

   // Input synchroniser, stability counter and last-accepted code
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         cand     <= '0;
         last_acc <= '0;
         cnt      <= '0;
      end else begin
         sync1 <= coil_in;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= CW'(1);
         end else if (cnt != CNT_FULL) begin
            cnt <= cnt + 1'b1;
         end
         if (accept)
            last_acc <= cand;
      end
   end

   assign accept = (cnt == CNT_FULL) && (cand != last_acc);
   assign diff   = ph_idx - ref_idx;

   // Phase table lookup of the candidate code
   always_comb begin
      ph_valid = 1'b1;
      ph_idx   = 2'd0;
      case (cand)
         CODE_P0: ph_idx = 2'd0;
         CODE_P1: ph_idx = 2'd1;
         CODE_P2: ph_idx = 2'd2;
         CODE_P3: ph_idx = 2'd3;
         default: ph_valid = 1'b0;
      endcase
   end

   // State, position and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_INIT;
         ref_idx    <= '0;
         floor      <= '0;
         sub_step   <= '0;
         step_dir   <= 1'b0;
         step_pulse <= 1'b0;
         at_floor   <= 1'b1;
         idle       <= 1'b1;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
      end else begin
         state      <= state_nx;
         ref_idx    <= ref_nx;
         floor      <= floor_nx;
         sub_step   <= sub_nx;
         step_dir   <= dir_nx;
         step_pulse <= pulse_nx;
         at_floor   <= (sub_nx == '0);
         idle       <= (state_nx == S_INIT) || (state_nx == S_IDLE);
         fault      <= (state_nx == S_FAULT);
         fault_code <= fcode_nx;
      end
   end

   // Next-state, sequence check and position update
   always_comb begin
      state_nx = state;
      ref_nx   = ref_idx;
      floor_nx = floor;
      sub_nx   = sub_step;
      dir_nx   = step_dir;
      pulse_nx = 1'b0;
      fcode_nx = fault_code;
      case (state)
         S_INIT, S_IDLE: begin
            if (accept) begin
               if (ph_valid) begin
                  ref_nx   = ph_idx;
                  state_nx = S_TRACK;
               end else if (cand == CODE_OFF) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx = S_FAULT;
                  fcode_nx = FC_ILLEGAL;
               end
            end
         end
         S_TRACK: begin
            if (accept) begin
               if (!ph_valid) begin
                  if (cand == CODE_OFF) begin
                     state_nx = S_IDLE;
                  end else begin
                     state_nx = S_FAULT;
                     fcode_nx = FC_ILLEGAL;
                  end
               end else if (diff == 2'd2) begin
                  state_nx = S_FAULT;
                  fcode_nx = FC_SKIP;
               end else if (diff == 2'd1) begin
                  if (floor == TOP_FLOOR && sub_step == '0) begin
                     state_nx = S_FAULT;
                     fcode_nx = FC_OVER;
                  end else begin
                     pulse_nx = 1'b1;
                     dir_nx   = 1'b0;
                     ref_nx   = ph_idx;
                     if (sub_step == SUB_MAX) begin
                        sub_nx   = '0;
                        floor_nx = floor + 4'd1;
                     end else begin
                        sub_nx = sub_step + 1'b1;
                     end
                  end
               end else if (diff == 2'd3) begin
                  if (floor == '0 && sub_step == '0) begin
                     state_nx = S_FAULT;
                     fcode_nx = FC_OVER;
                  end else begin
                     pulse_nx = 1'b1;
                     dir_nx   = 1'b1;
                     ref_nx   = ph_idx;
                     if (sub_step == '0) begin
                        sub_nx   = SUB_MAX;
                        floor_nx = floor - 4'd1;
                     end else begin
                        sub_nx = sub_step - 1'b1;
                     end
                  end
               end
            end
         end
         S_FAULT: begin
            if (clear_fault) begin
               state_nx = S_INIT;
               fcode_nx = FC_NONE;
            end
         end
         default: state_nx = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench for stepper_phase_decoder: stimulus pushes expected step and
// fault events, a negedge monitor pops and compares them when the DUT reports one.
module tb_stepper_phase_decoder;

   localparam int SPF = 48;
   localparam int NF  = 9;
   localparam int SC  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] coil_in;
   logic       clear_fault;
   logic       step_pulse, step_dir, at_floor, idle, fault;
   logic [3:0] floor;
   logic [5:0] sub_step;
   logic [1:0] fault_code;

   stepper_phase_decoder #(
      .STEPS_PER_FLOOR(SPF),
      .NUM_FLOORS     (NF),
      .STABLE_CYCLES  (SC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .coil_in    (coil_in),
      .clear_fault(clear_fault),
      .step_pulse (step_pulse),
      .step_dir   (step_dir),
      .floor      (floor),
      .sub_step   (sub_step),
      .at_floor   (at_floor),
      .idle       (idle),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_fault;
      bit dir;
      int flr;
      int sub;
      int fc;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [3:0] PH [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};
   int  idx = 0;
   int  exp_floor = 0;
   int  exp_sub = 0;
   bit  exp_dir = 1'b0;
   int  t_drive = 0;

   task automatic check(input string name, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, want);
   endtask

   // {pulse,dir,floor,sub,at_floor,idle,fault,fault_code} after reset
   task automatic check_reset(input string name);
      check(name, int'({step_pulse, step_dir, floor, sub_step, at_floor, idle, fault, fault_code}),
            int'({1'b0, 1'b0, 4'd0, 6'd0, 1'b1, 1'b1, 1'b0, 2'b00}));
   endtask

   task automatic drive(input logic [3:0] c);
      coil_in = c;
      t_drive = cyc;
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input bit f, input int fc);
      exp_t e;
      e.is_fault = f;
      e.dir      = exp_dir;
      e.flr      = exp_floor;
      e.sub      = exp_sub;
      e.fc       = fc;
      e.due      = t_drive + 3 + SC;
      sb.push_back(e);
   endtask

   task automatic step_up();
      idx = (idx + 1) % 4;
      drive(PH[idx]);
      if (exp_floor == NF - 1 && exp_sub == 0) begin
         push(1'b1, 3);
      end else begin
         exp_dir = 1'b0;
         if (exp_sub == SPF - 1) begin
            exp_sub = 0;
            exp_floor++;
         end else begin
            exp_sub++;
         end
         push(1'b0, 0);
      end
      hold(10);
   endtask

   task automatic step_down();
      idx = (idx + 3) % 4;
      drive(PH[idx]);
      if (exp_floor == 0 && exp_sub == 0) begin
         push(1'b1, 3);
      end else begin
         exp_dir = 1'b1;
         if (exp_sub == 0) begin
            exp_sub = SPF - 1;
            exp_floor--;
         end else begin
            exp_sub--;
         end
         push(1'b0, 0);
      end
      hold(10);
   endtask

   task automatic do_clear();
      clear_fault = 1'b1;
      hold(1);
      clear_fault = 1'b0;
   endtask

   // Monitor: every step pulse or fault assertion must match the next queued event
   bit fault_q = 1'b0;
   always @(negedge clk) begin
      if (step_pulse || (fault && !fault_q)) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got pulse=%0d fault=%0d floor=%0d sub=%0d at cyc %0d, want no event",
                     step_pulse, fault, floor, sub_step, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (step_pulse == !mon_e.is_fault && fault == mon_e.is_fault &&
                step_dir == mon_e.dir && int'(floor) == mon_e.flr &&
                int'(sub_step) == mon_e.sub && at_floor == (mon_e.sub == 0) &&
                int'(fault_code) == mon_e.fc && cyc == mon_e.due)
               n_pass++;
            else
               $display("FAIL event: got fault=%0d dir=%0d floor=%0d sub=%0d at_floor=%0d fc=%0d cyc=%0d, want fault=%0d dir=%0d floor=%0d sub=%0d fc=%0d cyc=%0d",
                        fault, step_dir, floor, sub_step, at_floor, fault_code, cyc,
                        mon_e.is_fault, mon_e.dir, mon_e.flr, mon_e.sub, mon_e.fc, mon_e.due);
         end
      end
      fault_q = fault;
   end

   initial begin
      rst_n       = 1'b0;
      coil_in     = 4'b0000;
      clear_fault = 1'b0;
      hold(3);
      check_reset("reset_values");
      rst_n = 1'b1;
      hold(10);
      check("init_idle", idle, 1);

      // reference on P0, then one floor of up travel
      idx = 0;
      drive(PH[idx]);
      hold(10);
      check("track_not_idle", idle, 0);
      for (int i = 0; i < SPF; i++) step_up();
      check("up_floor", floor, 1);
      check("up_sub", sub_step, 0);
      check("up_at_floor", at_floor, 1);

      // down three, then up one
      for (int i = 0; i < 3; i++) step_down();
      step_up();
      check("rev_floor", floor, 0);
      check("rev_sub", sub_step, 46);
      check("rev_dir", step_dir, 0);

      // power off and back on with P3
      drive(4'b0000);
      hold(10);
      check("off_idle", idle, 1);
      check("off_sub_held", sub_step, 46);
      idx = 3;
      drive(PH[idx]);
      hold(10);
      check("on_idle", idle, 0);
      check("on_sub_held", sub_step, 46);
      step_up();

      // glitch of STABLE_CYCLES-1 cycles while on P0
      drive(4'b1010);
      hold(SC - 1);
      drive(4'b1001);
      hold(12);
      check("glitch_sub", sub_step, 47);
      check("glitch_floor", floor, 0);
      check("glitch_fault", fault, 0);

      // skipped phase P0 -> P2
      idx = (idx + 2) % 4;
      drive(PH[idx]);
      push(1'b1, 2);
      hold(10);
      check("skip_code", fault_code, 2);
      do_clear();
      check("clear_fault", int'({fault, fault_code}), 0);
      check("clear_idle", idle, 1);

      // illegal code from INIT
      drive(4'b1111);
      push(1'b1, 1);
      hold(10);
      check("illegal_code", fault_code, 1);
      do_clear();

      // new reference, walk down to floor 0 / sub 0, then overtravel
      idx = (idx + 1) % 4;
      drive(PH[idx]);
      hold(10);
      for (int i = 0; i < 47; i++) step_down();
      check("bottom_sub", sub_step, 0);
      step_down();
      check("over_code", fault_code, 3);
      check("over_floor", floor, 0);
      check("over_sub", sub_step, 0);
      do_clear();

      // climb to floor 3
      idx = (idx + 1) % 4;
      drive(PH[idx]);
      hold(10);
      for (int i = 0; i < 3 * SPF; i++) step_up();
      check("climb_floor", floor, 3);

      // reset inside the filter window of a pending step
      idx = (idx + 1) % 4;
      drive(PH[idx]);
      hold(2);
      rst_n = 1'b0;
      hold(1);
      check_reset("mid_reset_values");
      rst_n = 1'b1;
      exp_floor = 0;
      exp_sub   = 0;
      exp_dir   = 1'b0;
      hold(15);
      check("post_reset_ref", int'({idle, floor, sub_step}), 0);

      hold(20);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
